// File: rtl/mac_stream_driver.sv
// mac_stream_driver
// Streams a locally buffered input vector to an accelerator over an AXI-Stream
// master port, then collects a fixed-length result vector from its AXI-Stream
// slave port into a readable result buffer.
//
// Handshake semantics (both ports): a word moves on a rising edge where
// tvalid && tready are both high. The master side holds tdata/tlast stable
// while tvalid is high and tready is low. The slave side asserts tready for
// the whole receive phase and accepts whatever tvalid presents, including gaps.
module mac_stream_driver #(
    parameter int DATA_WIDTH   = 32,
    parameter int INPUT_DIM    = 64,
    parameter int HIDDEN_UNITS = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            vec_we,
    input  logic [$clog2(INPUT_DIM)-1:0]    vec_addr,
    input  logic [DATA_WIDTH-1:0]           vec_wdata,
    input  logic [$clog2(HIDDEN_UNITS)-1:0] res_addr,
    output logic [DATA_WIDTH-1:0]           res_rdata,
    output logic                            busy,
    output logic                            done,
    output logic                            err_tlast,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [1:0]                      dbg_state
);

    localparam int IW = $clog2(INPUT_DIM);
    localparam int RW = $clog2(HIDDEN_UNITS);

    localparam logic [IW-1:0] LAST_IN  = IW'(INPUT_DIM - 1);
    localparam logic [RW-1:0] LAST_RES = RW'(HIDDEN_UNITS - 1);
    localparam logic [IW-1:0] ONE_IN   = IW'(1);
    localparam logic [RW-1:0] ONE_RES  = RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] vec_buf [INPUT_DIM];
    logic [DATA_WIDTH-1:0] res_buf [HIDDEN_UNITS];

    logic [IW-1:0] send_idx;
    logic [RW-1:0] recv_idx;
    logic          done_q;
    logic          err_q;

    // Decoded conditions shared by the state machine and the datapath.
    logic quiescent;   // IDLE or DONE: buffer writes and start are honoured
    logic start_ok;    // start accepted at this edge
    logic m_fire;      // outgoing word transferred at this edge
    logic s_fire;      // incoming word accepted at this edge
    logic send_last;   // current outgoing word is the final one
    logic recv_last;   // current incoming word is the final one

    assign quiescent = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok  = quiescent && start;
    assign m_fire    = (state == ST_SEND) && m_axis_tready;
    assign s_fire    = (state == ST_RECV) && s_axis_tvalid;
    assign send_last = (send_idx == LAST_IN);
    assign recv_last = (recv_idx == LAST_RES);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the state-derived handshake/status outputs.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = send_last;
                if (m_fire && send_last) begin
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                busy          = 1'b1;
                s_axis_tready = 1'b1;
                if (s_fire && recv_last) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Send and receive word counters; both restart on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send_idx <= '0;
            recv_idx <= '0;
        end else if (start_ok) begin
            send_idx <= '0;
            recv_idx <= '0;
        end else begin
            if (m_fire) begin
                send_idx <= send_idx + ONE_IN;
            end
            if (s_fire) begin
                recv_idx <= recv_idx + ONE_RES;
            end
        end
    end

    // Sticky completion and tlast-position error flags, cleared by a new start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (start_ok) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (s_fire) begin
            if (recv_last) begin
                done_q <= 1'b1;
            end
            // tlast must appear on the final word and nowhere else.
            if (s_axis_tlast != recv_last) begin
                err_q <= 1'b1;
            end
        end
    end

    // Input-vector buffer: host writes land only while no transfer is active,
    // so a write coinciding with start is part of the vector being sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < INPUT_DIM; i++) begin
                vec_buf[i] <= '0;
            end
        end else if (vec_we && quiescent) begin
            vec_buf[vec_addr] <= vec_wdata;
        end
    end

    // Result buffer: filled in arrival order, kept until a later transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HIDDEN_UNITS; i++) begin
                res_buf[i] <= '0;
            end
        end else if (s_fire) begin
            res_buf[recv_idx] <= s_axis_tdata;
        end
    end

    // The outgoing word follows send_idx, which only moves on a transfer,
    // so the word is inherently stable across back-pressure.
    assign m_axis_tdata = vec_buf[send_idx];
    assign res_rdata    = res_buf[res_addr];
    assign done         = done_q;
    assign err_tlast    = err_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_mac_stream_driver.sv
// Bench for mac_stream_driver: randomized accelerator/back-pressure stimulus,
// a transaction-level reference model, and a per-cycle compare process.
module tb_mac_stream_driver;

    localparam int DW = 32;
    localparam int ID = 64;
    localparam int HU = 64;

    logic          clk;
    logic          rst;
    logic          start;
    logic          vec_we;
    logic [5:0]    vec_addr;
    logic [DW-1:0] vec_wdata;
    logic [5:0]    res_addr;
    logic [DW-1:0] res_rdata;
    logic          busy;
    logic          done;
    logic          err_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [1:0]    dbg_state;

    mac_stream_driver #(
        .DATA_WIDTH  (DW),
        .INPUT_DIM   (ID),
        .HIDDEN_UNITS(HU)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vec_we       (vec_we),
        .vec_addr     (vec_addr),
        .vec_wdata    (vec_wdata),
        .res_addr     (res_addr),
        .res_rdata    (res_rdata),
        .busy         (busy),
        .done         (done),
        .err_tlast    (err_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and check helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: an accepted start snapshots the vector into exp_q;
    // words leave the queue as they are transferred; once it is empty the
    // driver collects HU results, then the transaction is complete.
    logic [DW-1:0] m_vec [ID];
    logic [DW-1:0] m_res [HU];
    logic [DW-1:0] exp_q [$];
    bit            m_active;
    bit            m_done;
    bit            m_err;
    int            m_recv;
    int            m_fire_cnt = 0;
    bit            s_fire_q   = 1'b0;
    logic [DW-1:0] out_data [$];
    bit            out_last [$];

    // Compare process: checks every output against the model each cycle,
    // then advances the model by the handshakes happening at the next edge.
    always @(negedge clk) begin
        bit e_valid;
        bit e_ready;
        bit was_active;
        if (!rst) begin
            for (int i = 0; i < ID; i++) m_vec[i] = '0;
            for (int i = 0; i < HU; i++) m_res[i] = '0;
            exp_q.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_recv   = 0;
        end
        e_valid    = m_active && (exp_q.size() > 0);
        e_ready    = m_active && (exp_q.size() == 0);
        was_active = m_active;

        chk1("busy", busy, m_active);
        chk1("done", done, m_done);
        chk1("err_tlast", err_tlast, m_err);
        chk1("m_tvalid", m_axis_tvalid, e_valid);
        chk1("s_tready", s_axis_tready, e_ready);
        if (e_valid) begin
            chk("m_tdata", m_axis_tdata, exp_q[0]);
            chk1("m_tlast", m_axis_tlast, exp_q.size() == 1);
        end else begin
            chk1("m_tlast_idle", m_axis_tlast, 1'b0);
        end
        chk("res_rdata", res_rdata, m_res[res_addr]);

        s_fire_q = s_axis_tvalid && s_axis_tready;
        if (rst) begin
            if (e_valid && m_axis_tready) begin
                out_data.push_back(m_axis_tdata);
                out_last.push_back(m_axis_tlast);
                void'(exp_q.pop_front());
                m_fire_cnt++;
            end
            if (e_ready && s_axis_tvalid) begin
                m_res[m_recv] = s_axis_tdata;
                if (s_axis_tlast != (m_recv == HU - 1)) m_err = 1'b1;
                m_recv++;
                if (m_recv == HU) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
            if (!was_active && vec_we) m_vec[vec_addr] = vec_wdata;
            if (!was_active && start) begin
                exp_q.delete();
                for (int i = 0; i < ID; i++) exp_q.push_back(m_vec[i]);
                m_active = 1'b1;
                m_done   = 1'b0;
                m_err    = 1'b0;
                m_recv   = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit            rdy_rand = 1'b0;
    bit            gap_rand = 1'b0;
    int            acc_idx  = HU;
    int            acc_tlast_pos = HU - 1;
    logic [DW-1:0] acc_base = '0;

    task automatic drive_acc();
        if (acc_idx < HU) begin
            s_axis_tvalid = gap_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata  = acc_base + DW'(acc_idx);
            s_axis_tlast  = (acc_idx == acc_tlast_pos);
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        start  = 1'b0;
        vec_we = 1'b0;
        if (s_fire_q) acc_idx++;
        drive_acc();
        m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        res_addr      = 6'($urandom_range(0, HU - 1));
    endtask

    task automatic load_vec(input int idx, input logic [DW-1:0] data);
        vec_we    = 1'b1;
        vec_addr  = 6'(idx);
        vec_wdata = data;
        tick();
    endtask

    task automatic start_txn(input logic [DW-1:0] base, input int tlast_pos);
        acc_idx       = 0;
        acc_base      = base;
        acc_tlast_pos = tlast_pos;
        out_data.delete();
        out_last.delete();
        drive_acc();
        start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        chk1("done_reached", done, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int n;
        int nz;
        int lasts;
        int fc0;

        rst           = 1'b0;
        start         = 1'b0;
        vec_we        = 1'b0;
        vec_addr      = '0;
        vec_wdata     = '0;
        res_addr      = '0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err_tlast, 1'b0);
        chk1("rst_tvalid", m_axis_tvalid, 1'b0);
        chk1("rst_tlast", m_axis_tlast, 1'b0);
        chk1("rst_tready", s_axis_tready, 1'b0);
        chk("rst_rdata", res_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // Basic transaction, always ready, with exact latency.
        rdy_rand = 1'b0;
        gap_rand = 1'b0;
        for (int i = 0; i < ID; i++) load_vec(i, DW'(i + 1));
        start_txn(32'h100, HU - 1);
        wait_done(400, cyc);
        chk("latency", DW'(cyc + 1), 32'd129);
        chk1("t1_err", err_tlast, 1'b0);
        chk("t1_count", DW'(out_data.size()), 32'd64);
        chk("t1_first", out_data[0], 32'd1);
        chk("t1_last", out_data[63], 32'd64);
        lasts = 0;
        foreach (out_last[i]) if (out_last[i]) lasts++;
        chk("t1_tlast_cnt", DW'(lasts), 32'd1);
        chk1("t1_tlast_pos", out_last[63], 1'b1);
        res_addr = 6'd0;
        #1 chk("t1_res0", res_rdata, 32'h100);
        res_addr = 6'd63;
        #1 chk("t1_res63", res_rdata, 32'h13f);

        // Random back-pressure and source gaps, random data, write-with-start.
        rdy_rand = 1'b1;
        gap_rand = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            for (int i = 0; i < ID; i++) load_vec(i, DW'($urandom));
            vec_we    = 1'b1;
            vec_addr  = 6'($urandom_range(0, ID - 1));
            vec_wdata = DW'($urandom);
            start_txn(DW'($urandom), HU - 1);
            wait_done(3000, cyc);
            chk1("rnd_err", err_tlast, 1'b0);
            chk("rnd_count", DW'(out_data.size()), 32'd64);
        end

        // Result tlast on word 10 only.
        rdy_rand = 1'b0;
        tick();
        start_txn(32'h200, 10);
        wait_done(3000, cyc);
        chk1("tl_err", err_tlast, 1'b1);
        chk1("tl_done", done, 1'b1);
        res_addr = 6'd63;
        #1 chk("tl_res63", res_rdata, 32'h23f);

        // Buffer write while sending is ignored.
        gap_rand = 1'b0;
        tick();
        load_vec(5, 32'hcafe0005);
        start_txn(32'h300, HU - 1);
        vec_we    = 1'b1;
        vec_addr  = 6'd5;
        vec_wdata = 32'hdeadbeef;
        wait_done(400, cyc);
        chk("we_busy_w5", out_data[5], 32'hcafe0005);
        tick();
        start_txn(32'h310, HU - 1);
        wait_done(400, cyc);
        chk("we_after_w5", out_data[5], 32'hcafe0005);

        // Reset after 20 sent words.
        tick();
        fc0 = m_fire_cnt;
        start_txn(32'h400, HU - 1);
        n = 0;
        while ((m_fire_cnt - fc0) < 20 && n < 200) begin
            tick();
            n++;
        end
        chk("rs_sent", DW'(m_fire_cnt - fc0), 32'd20);
        rst = 1'b0;
        #1;
        chk1("rs_tvalid", m_axis_tvalid, 1'b0);
        chk1("rs_busy", busy, 1'b0);
        chk1("rs_tready", s_axis_tready, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        start_txn(32'h410, HU - 1);
        wait_done(400, cyc);
        nz = 0;
        foreach (out_data[i]) if (out_data[i] != '0) nz++;
        chk("rs_zero_words", DW'(nz), 32'd0);
        chk("rs_count", DW'(out_data.size()), 32'd64);

        // Start during RECV is ignored; start in DONE begins a new transaction.
        rdy_rand = 1'b1;
        gap_rand = 1'b1;
        tick();
        for (int i = 0; i < ID; i++) load_vec(i, DW'($urandom));
        start_txn(32'h500, HU - 1);
        n = 0;
        while (s_axis_tready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk1("sr_in_recv", s_axis_tready, 1'b1);
        start = 1'b1;
        tick();
        wait_done(3000, cyc);
        chk("sr_count", DW'(out_data.size()), 32'd64);
        start_txn(32'h600, HU - 1);
        chk1("sd_done_clr", done, 1'b0);
        chk1("sd_busy", busy, 1'b1);
        wait_done(3000, cyc);
        chk1("sd_err", err_tlast, 1'b0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
